// File: rtl/pop_scheduler.sv
// pop_scheduler
//   Sequencing controller between the per-class input FIFOs and the weighted
//   round-robin arbiter. Holds the arbiter weights, runs the system FSM
//   (RESET/INIT/IDLE/ACTIVE/ERROR), turns the arbiter grant into a one-hot
//   FIFO pop, registers the popped word and flags FIFO overflow as a sticky
//   error.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-low reset
//   enb               global enable; 0 blocks pops and holds state
//   init              configuration request; weights load while high in INIT
//   pesos_in          weight configuration, queue 0 in the LSBs
//   buf_empty         per-FIFO empty flags
//   fifo_overflow     per-FIFO overflow pulses
//   fifo_data         show-ahead FIFO heads, queue 0 in the LSBs
//   selector          arbiter grant index
//   selector_enb      arbiter grant valid
//   down_almost_full  downstream back-pressure
//   pesos             registered weights to the arbiter
//   pop               one-hot FIFO read strobe (combinational)
//   data_out          registered popped word
//   valid_out         data_out valid, one cycle per pop
//   state             one-hot FSM state
//   error_out         high in ERROR
//   idle_out          high in IDLE
module pop_scheduler #(
    parameter  int QUEUE_QUANTITY = 4,
    parameter  int DATA_BITS      = 8,
    parameter  int MAX_WEIGHT     = 64,
    localparam int WEIGHT_BITS    = $clog2(MAX_WEIGHT),
    localparam int SEL_BITS       = $clog2(QUEUE_QUANTITY)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enb,
    input  logic                                  init,
    input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] pesos_in,
    input  logic [QUEUE_QUANTITY-1:0]             buf_empty,
    input  logic [QUEUE_QUANTITY-1:0]             fifo_overflow,
    input  logic [QUEUE_QUANTITY*DATA_BITS-1:0]   fifo_data,
    input  logic [SEL_BITS-1:0]                   selector,
    input  logic                                  selector_enb,
    input  logic                                  down_almost_full,
    output logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] pesos,
    output logic [QUEUE_QUANTITY-1:0]             pop,
    output logic [DATA_BITS-1:0]                  data_out,
    output logic                                  valid_out,
    output logic [4:0]                            state,
    output logic                                  error_out,
    output logic                                  idle_out
);

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t                                r_state;
    state_t                                w_next_state;
    logic                                  w_pop_fire;
    logic                                  w_any_overflow;
    logic                                  w_all_empty;
    logic [DATA_BITS-1:0]                  w_pop_data;
    logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] r_pesos;
    logic [DATA_BITS-1:0]                  r_data_out;
    logic                                  r_valid_out;

    assign w_any_overflow = |fifo_overflow;
    assign w_all_empty    = &buf_empty;
    assign w_pop_data     = fifo_data[int'(selector)*DATA_BITS +: DATA_BITS];

    // A grant becomes a pop only when the FSM is running, the granted queue
    // actually has data and downstream can accept it; otherwise the grant
    // is simply dropped for this cycle.
    assign w_pop_fire = (r_state == ST_ACTIVE) && enb && selector_enb &&
                        !buf_empty[selector] && !down_almost_full;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, priority top-down.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would infer a latch.
        w_next_state = r_state;
        if (r_state == ST_RESET) begin
            w_next_state = ST_INIT;
        end else if (init) begin
            w_next_state = ST_INIT;
        end else if (r_state != ST_ERROR && w_any_overflow) begin
            w_next_state = ST_ERROR;
        end else begin
            case (r_state)
                ST_INIT:   w_next_state = ST_IDLE;
                ST_IDLE:   if (enb && !w_all_empty) w_next_state = ST_ACTIVE;
                // enb=0 freezes ACTIVE even once every queue drains.
                ST_ACTIVE: if (enb && w_all_empty && !w_pop_fire) w_next_state = ST_IDLE;
                ST_ERROR:  w_next_state = ST_ERROR;
                default:   w_next_state = ST_RESET;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        pop = '0;
        if (w_pop_fire) pop[selector] = 1'b1;
    end

    assign state     = r_state;
    assign error_out = (r_state == ST_ERROR);
    assign idle_out  = (r_state == ST_IDLE);

    // Weight configuration and registered output stage. A pop that fires in
    // the same cycle as overflow or init still completes and is captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pesos     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            if (r_state == ST_INIT && init) r_pesos <= pesos_in;
            r_valid_out <= w_pop_fire;
            if (w_pop_fire) r_data_out <= w_pop_data;
        end
    end

    assign pesos     = r_pesos;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_pop_scheduler.sv
// tb_pop_scheduler
//   Directed scenarios plus a randomized run for pop_scheduler. A
//   behavioural model (mode number, weight/data registers) tracks the
//   expected outputs from the scheduler's rules every cycle.
module tb_pop_scheduler;

    localparam int QQ = 4;
    localparam int DB = 8;
    localparam int WB = 6;
    localparam int SB = 2;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             enb;
    logic             init;
    logic [QQ*WB-1:0] pesos_in;
    logic [QQ-1:0]    buf_empty;
    logic [QQ-1:0]    fifo_overflow;
    logic [QQ*DB-1:0] fifo_data;
    logic [SB-1:0]    selector;
    logic             selector_enb;
    logic             down_almost_full;
    logic [QQ*WB-1:0] pesos;
    logic [QQ-1:0]    pop;
    logic [DB-1:0]    data_out;
    logic             valid_out;
    logic [4:0]       state;
    logic             error_out;
    logic             idle_out;

    logic [DB-1:0]    lanes [QQ];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int               m_mode;
    logic [QQ*WB-1:0] m_pesos;
    logic [DB-1:0]    m_data;
    logic             m_valid;

    pop_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .enb              (enb),
        .init             (init),
        .pesos_in         (pesos_in),
        .buf_empty        (buf_empty),
        .fifo_overflow    (fifo_overflow),
        .fifo_data        (fifo_data),
        .selector         (selector),
        .selector_enb     (selector_enb),
        .down_almost_full (down_almost_full),
        .pesos            (pesos),
        .pop              (pop),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .state            (state),
        .error_out        (error_out),
        .idle_out         (idle_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        fifo_data = '0;
        for (int q = 0; q < QQ; q++) fifo_data[q*DB +: DB] = lanes[q];
    end

    task automatic model_reset();
        m_mode  = M_RESET;
        m_pesos = '0;
        m_data  = '0;
        m_valid = 1'b0;
    endtask

    function automatic logic model_fire();
        return (m_mode == M_ACTIVE) && enb && selector_enb &&
               !buf_empty[selector] && !down_almost_full;
    endfunction

    task automatic model_edge(input logic fire);
        int nxt;
        if (m_mode == M_INIT && init) m_pesos = pesos_in;
        m_valid = fire;
        if (fire) m_data = lanes[selector];
        nxt = m_mode;
        if (m_mode == M_RESET)                            nxt = M_INIT;
        else if (init)                                    nxt = M_INIT;
        else if (m_mode != M_ERROR && fifo_overflow != 0) nxt = M_ERROR;
        else if (m_mode == M_INIT)                        nxt = M_IDLE;
        else if (m_mode == M_IDLE && enb && buf_empty != '1) nxt = M_ACTIVE;
        else if (m_mode == M_ACTIVE && enb && buf_empty == '1 && !fire) nxt = M_IDLE;
        m_mode = nxt;
    endtask

    // One clock: entered just after a falling edge with inputs applied.
    // Compares pop and registered outputs before the edge, then the
    // registered outputs after it, and returns on the next falling edge.
    task automatic cycle(input string tag);
        logic [QQ-1:0] exp_pop;
        logic [39:0]   exp_regs;
        logic          fire;
        #1;
        if (!rst) model_reset();
        fire    = model_fire();
        exp_pop = '0;
        for (int q = 0; q < QQ; q++) if (fire && q == int'(selector)) exp_pop[q] = 1'b1;
        n_total++;
        if (pop !== exp_pop) $display("FAIL %s pop got %b expected %b", tag, pop, exp_pop);
        else n_pass++;
        exp_regs = {5'(1 << m_mode), m_pesos, m_data, m_valid, m_mode == M_ERROR, m_mode == M_IDLE};
        n_total++;
        if ({state, pesos, data_out, valid_out, error_out, idle_out} !== exp_regs)
            $display("FAIL %s pre-edge regs got %h expected %h", tag,
                     {state, pesos, data_out, valid_out, error_out, idle_out}, exp_regs);
        else n_pass++;
        @(posedge clk);
        if (rst) model_edge(fire);
        else model_reset();
        #1;
        exp_regs = {5'(1 << m_mode), m_pesos, m_data, m_valid, m_mode == M_ERROR, m_mode == M_IDLE};
        n_total++;
        if ({state, pesos, data_out, valid_out, error_out, idle_out} !== exp_regs)
            $display("FAIL %s post-edge regs got %h expected %h", tag,
                     {state, pesos, data_out, valid_out, error_out, idle_out}, exp_regs);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; enb = 1'b1; init = 1'b0; pesos_in = '0;
        buf_empty = '1; fifo_overflow = '0; selector = '0;
        selector_enb = 1'b0; down_almost_full = 1'b0;
        for (int q = 0; q < QQ; q++) lanes[q] = '0;
        cycle("reset0");
        cycle("reset1");
        n_total++;
        if (state !== 5'b00001) $display("FAIL reset_state got %b expected %b", state, 5'b00001);
        else n_pass++;
        rst = 1'b1; init = 1'b1; pesos_in = {6'd6, 6'd3, 6'd2, 6'd1};
        cycle("cfg0");
        n_total++;
        if (state !== 5'b00010) $display("FAIL cfg_init_state got %b expected %b", state, 5'b00010);
        else n_pass++;
        cycle("cfg1");
        init = 1'b0;
        cycle("cfg2");
        n_total++;
        if (state !== 5'b00100) $display("FAIL cfg_idle_state got %b expected %b", state, 5'b00100);
        else n_pass++;
        n_total++;
        if (pesos !== {6'd6, 6'd3, 6'd2, 6'd1})
            $display("FAIL cfg_pesos got %h expected %h", pesos, {6'd6, 6'd3, 6'd2, 6'd1});
        else n_pass++;
    endtask

    task automatic test_single_pop();
        buf_empty = 4'b1011; selector = 2'd2; selector_enb = 1'b0;
        cycle("sp_wake");
        selector_enb = 1'b1; lanes[2] = 8'hA5; lanes[0] = 8'h11;
        #1;
        n_total++;
        if (pop !== 4'b0100) $display("FAIL single_pop pop got %b expected %b", pop, 4'b0100);
        else n_pass++;
        cycle("sp_pop");
        n_total++;
        if (data_out !== 8'hA5 || valid_out !== 1'b1 || state !== 5'b01000)
            $display("FAIL single_pop_out got data=%h valid=%b state=%b expected data=a5 valid=1 state=01000",
                     data_out, valid_out, state);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] v;
        buf_empty = 4'b0000; selector = 2'd1; selector_enb = 1'b1;
        down_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (pop !== 4'b0000) $display("FAIL bp_pop[%0d] got %b expected 0000", i, pop);
            else n_pass++;
            cycle("bp_hold");
            n_total++;
            if (valid_out !== 1'b0 || state !== 5'b01000)
                $display("FAIL bp_valid[%0d] got valid=%b state=%b expected valid=0 state=01000", i, valid_out, state);
            else n_pass++;
        end
        down_almost_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = DB'($urandom);
            lanes[1] = v;
            #1;
            n_total++;
            if (pop !== 4'b0010) $display("FAIL b2b_pop[%0d] got %b expected 0010", i, pop);
            else n_pass++;
            cycle("b2b");
            n_total++;
            if (valid_out !== 1'b1 || data_out !== v)
                $display("FAIL b2b_data[%0d] got valid=%b data=%h expected valid=1 data=%h", i, valid_out, data_out, v);
            else n_pass++;
        end
    endtask

    task automatic test_empty_grant();
        buf_empty = 4'b1000; selector = 2'd3; selector_enb = 1'b1;
        #1;
        n_total++;
        if (pop !== 4'b0000) $display("FAIL empty_grant_pop got %b expected 0000", pop);
        else n_pass++;
        cycle("empty_grant");
        n_total++;
        if (valid_out !== 1'b0 || error_out !== 1'b0 || state !== 5'b01000)
            $display("FAIL empty_grant_out got valid=%b err=%b state=%b expected valid=0 err=0 state=01000",
                     valid_out, error_out, state);
        else n_pass++;
    endtask

    task automatic test_drain();
        buf_empty = 4'b1111; selector_enb = 1'b0;
        cycle("drain");
        n_total++;
        if (state !== 5'b00100 || idle_out !== 1'b1)
            $display("FAIL drain got state=%b idle=%b expected state=00100 idle=1", state, idle_out);
        else n_pass++;
    endtask

    task automatic test_init_active();
        buf_empty = 4'b0000; selector_enb = 1'b0;
        cycle("ia_wake");
        init = 1'b1; selector = 2'd0; selector_enb = 1'b1; lanes[0] = 8'h3C;
        pesos_in = {6'd40, 6'd20, 6'd10, 6'd5};
        #1;
        n_total++;
        if (pop !== 4'b0001) $display("FAIL init_active_pop got %b expected 0001", pop);
        else n_pass++;
        cycle("ia_pop");
        n_total++;
        if (state !== 5'b00010 || valid_out !== 1'b1 || data_out !== 8'h3C)
            $display("FAIL init_active_out got state=%b valid=%b data=%h expected state=00010 valid=1 data=3c",
                     state, valid_out, data_out);
        else n_pass++;
        cycle("ia_load");
        n_total++;
        if (pesos !== {6'd40, 6'd20, 6'd10, 6'd5} || pop !== 4'b0000)
            $display("FAIL init_active_load got pesos=%h pop=%b expected pesos=%h pop=0000",
                     pesos, pop, {6'd40, 6'd20, 6'd10, 6'd5});
        else n_pass++;
        init = 1'b0; buf_empty = 4'b1111; selector_enb = 1'b0;
        cycle("ia_idle");
    endtask

    task automatic test_error();
        buf_empty = 4'b0000; selector_enb = 1'b0;
        cycle("err_wake");
        fifo_overflow = 4'b0010; selector = 2'd0; selector_enb = 1'b1; lanes[0] = 8'h5A;
        cycle("err_ovf");
        n_total++;
        if (state !== 5'b10000 || error_out !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'h5A)
            $display("FAIL err_enter got state=%b err=%b valid=%b data=%h expected state=10000 err=1 valid=1 data=5a",
                     state, error_out, valid_out, data_out);
        else n_pass++;
        fifo_overflow = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            selector = SB'(i + 1);
            #1;
            n_total++;
            if (pop !== 4'b0000 || error_out !== 1'b1)
                $display("FAIL err_hold[%0d] got pop=%b err=%b expected pop=0000 err=1", i, pop, error_out);
            else n_pass++;
            cycle("err_hold");
        end
        init = 1'b1;
        cycle("err_init");
        n_total++;
        if (state !== 5'b00010 || error_out !== 1'b0)
            $display("FAIL err_exit got state=%b err=%b expected state=00010 err=0", state, error_out);
        else n_pass++;
        init = 1'b0;
        cycle("err_idle");
        cycle("err_wake2");
        fifo_overflow = 4'b0100;
        cycle("err_ovf2");
        fifo_overflow = 4'b0000;
        rst = 1'b0;
        #1;
        n_total++;
        if (state !== 5'b00001 || pesos !== '0 || data_out !== '0 || valid_out !== 1'b0 ||
            error_out !== 1'b0 || idle_out !== 1'b0 || pop !== 4'b0000)
            $display("FAIL err_async_reset got state=%b pesos=%h data=%h valid=%b err=%b idle=%b pop=%b expected all zero, state=00001",
                     state, pesos, data_out, valid_out, error_out, idle_out, pop);
        else n_pass++;
        cycle("err_rst");
        rst = 1'b1; init = 1'b1; pesos_in = {6'd1, 6'd2, 6'd3, 6'd4};
        cycle("recfg0");
        cycle("recfg1");
        init = 1'b0;
        cycle("recfg2");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst              = ($urandom_range(0, 63) != 0);
            init             = ($urandom_range(0, 19) == 0);
            enb              = ($urandom_range(0, 7) != 0);
            fifo_overflow    = ($urandom_range(0, 39) == 0) ? QQ'(1 << $urandom_range(0, QQ - 1)) : '0;
            buf_empty        = ($urandom_range(0, 5) == 0) ? '1 : QQ'($urandom);
            selector         = SB'($urandom);
            selector_enb     = ($urandom_range(0, 3) != 0);
            down_almost_full = ($urandom_range(0, 3) == 0);
            pesos_in         = (QQ*WB)'($urandom);
            for (int q = 0; q < QQ; q++) lanes[q] = DB'($urandom);
            cycle("random");
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_pop();
        test_back_to_back();
        test_empty_grant();
        test_drain();
        test_init_active();
        test_error();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pop_scheduler.md
Name: pop_scheduler

Overview:
- Sequencing controller between the per-class input FIFOs and the weighted round-robin arbiter.
- Holds the arbiter weight configuration, runs the system FSM (RESET/INIT/IDLE/ACTIVE/ERROR) and turns the arbiter grant (selector/selector_enb) into a one-hot FIFO pop.
- Captures the popped word into a registered output stage and honours downstream back-pressure.
- Flags FIFO overflow as a sticky error.

Parameters:
QUEUE_QUANTITY, 4, number of input FIFOs; power of two, >=2
DATA_BITS, 8, FIFO word width
MAX_WEIGHT, 64, maximum arbiter weight; WEIGHT_BITS = $clog2(MAX_WEIGHT)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
enb  in  1  global enable; when 0 no pops issue and state holds (init, overflow and reset still act)
init  in  1  configuration request; weights load while high
pesos_in  in  QUEUE_QUANTITY*WEIGHT_BITS  weight configuration, queue 0 in LSBs
buf_empty  in  QUEUE_QUANTITY  per-FIFO empty flags
fifo_overflow  in  QUEUE_QUANTITY  per-FIFO overflow pulses
fifo_data  in  QUEUE_QUANTITY*DATA_BITS  show-ahead FIFO heads, queue 0 in LSBs
selector  in  $clog2(QUEUE_QUANTITY)  arbiter grant index
selector_enb  in  1  arbiter grant valid
down_almost_full  in  1  downstream back-pressure
pesos  out  QUEUE_QUANTITY*WEIGHT_BITS  registered weights to arbiter
pop  out  QUEUE_QUANTITY  one-hot FIFO read strobe (combinational)
data_out  out  DATA_BITS  registered popped word
valid_out  out  1  data_out valid, one cycle per pop
state  out  5  one-hot FSM state
error_out  out  1  high in ERROR
idle_out  out  1  high in IDLE

Behaviour:
- Reset values (rst low, asynchronous): state=RESET (5'b00001), pesos=0, data_out=0, valid_out=0, error_out=0, idle_out=0.
- pop is 0 while rst is low.
- State encoding:
  - RESET=00001
  - INIT=00010
  - IDLE=00100
  - ACTIVE=01000
  - ERROR=10000
- Transitions (registered, priority top-down):
  - RESET -> INIT on first edge after rst deasserts.
  - Any state except RESET -> INIT when init=1.
  - INIT/IDLE/ACTIVE -> ERROR when |fifo_overflow. ERROR is sticky until init or reset.
  - INIT -> IDLE when init=0.
  - IDLE -> ACTIVE when enb=1 and buf_empty != all ones.
  - ACTIVE -> IDLE when buf_empty is all ones and no pop fires this cycle.
  - Otherwise hold.
- Weights: pesos <= pesos_in on every edge with state=INIT and init=1. Otherwise pesos holds its value, including across ERROR.
- Pop rule, combinational, in the cycle the grant is presented:
  - pop[selector]=1 iff state=ACTIVE, enb=1, selector_enb=1, buf_empty[selector]=0, down_almost_full=0.
  - All other pop bits are 0.
  - pop is never asserted in RESET/INIT/IDLE/ERROR.
- Output stage:
  - On an edge where a pop fired: data_out <= fifo_data[selector*DATA_BITS +: DATA_BITS], valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds.
  - Latency: pop cycle N -> valid_out in cycle N+1.
- Grant on an empty queue (selector_enb=1, buf_empty[selector]=1): no pop, no error; the cycle is dropped.
- down_almost_full=1 blocks pops; the grant is lost that cycle and state stays ACTIVE.
- Overflow and pop in the same cycle: the pop still fires and data is captured, valid_out=1 next cycle; the state moves to ERROR.
- init during ACTIVE: the in-flight pop of that cycle completes and captures data; the next state is INIT with no further pops.
- error_out = (state==ERROR); idle_out = (state==IDLE); both are registered via state.

Test Plan:
- Reset/config: rst=0 for 2 cycles then 1, init=1 for 2 cycles with pesos_in={6'd6,6'd3,6'd2,6'd1}.
  -> state RESET->INIT->IDLE; pesos equals pesos_in; pop=0 throughout.
- Single pop: buf_empty=4'b1011, selector=2, selector_enb=1, fifo_data lane2=8'hA5.
  -> pop=4'b0100 in that cycle; next cycle data_out=8'hA5, valid_out=1; ACTIVE.
- Back-pressure: continuous grants to queue 1, down_almost_full=1 for 3 cycles.
  -> pop=0 and valid_out=0 for those 3 cycles; pops resume the cycle after release.
- Empty grant: selector=3, buf_empty[3]=1, others non-empty.
  -> pop=0, valid_out=0 next cycle, error_out=0.
- Drain to idle: all buf_empty go 1 with no grant.
  -> ACTIVE->IDLE on next edge; idle_out=1.
- Error: fifo_overflow=4'b0010 pulse in ACTIVE.
  -> state=ERROR, error_out=1, pop held 0 despite grants.
  -> init=1 returns to INIT; mid-ERROR rst=0 forces RESET and zeroes all outputs immediately.
